// File: rtl/seven_segment_capture.sv
// Receive-side monitor for a multiplexed seven-segment display. Each digit slot
// must hold steady for a number of cycles, then its pattern is decoded to hex.
// Once the eighth digit arrives, the assembled frame is published.
module seven_segment_capture #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic [7:0]  segmentEnableN,
  input  logic [7:0]  digitEnableN,
  output logic [31:0] data,
  output logic [7:0]  pointMask,
  output logic [7:0]  digitValid,
  output logic        frameValid,
  output logic        frameError
);

  typedef enum logic [1:0] {
    SLOT_BLANK,
    SLOT_SINGLE,
    SLOT_MULTI
  } slot_kind_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  logic [15:0] sample_q, sample_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        accepted_q, accepted_d;
  logic [31:0] sh_nib_q, sh_nib_d;
  logic [7:0]  sh_pt_q, sh_pt_d;
  logic [7:0]  sh_val_q, sh_val_d;
  logic [7:0]  seen_q, seen_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  point_q, point_d;
  logic [7:0]  valid_q, valid_d;
  logic        fv_q, fv_d;
  logic        fe_q, fe_d;

  logic        changed;
  logic        accept;
  logic [7:0]  seg_s;
  logic [7:0]  en_s;
  logic [3:0]  zeros;
  logic [2:0]  idx;
  slot_kind_e  kind;
  logic [4:0]  dec;
  logic        dec_ok;
  logic [3:0]  dec_nib;
  logic        pt_now;
  logic        digit_evt;
  logic        multi_evt;
  logic        publish;

  // Returns {ok, nibble}; unrecognised patterns decode to nibble 0 with ok=0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h39:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Stability filter: the counter holds (run length - 1) of the current sample.
  always_comb begin
    sample_d   = {digitEnableN, segmentEnableN};
    changed    = (sample_d != sample_q);
    accept     = (cnt_q == SETTLE_LAST) && !accepted_q;
    if (changed) begin
      cnt_d      = '0;
      accepted_d = 1'b0;
    end else begin
      cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      accepted_d = accepted_q | accept;
    end
  end

  always_comb begin
    seg_s = sample_q[7:0];
    en_s  = sample_q[15:8];
    zeros = '0;
    idx   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!en_s[i]) begin
        zeros = zeros + 4'd1;
        idx   = 3'(i);
      end
    end
    if (zeros == 4'd0)      kind = SLOT_BLANK;
    else if (zeros == 4'd1) kind = SLOT_SINGLE;
    else                    kind = SLOT_MULTI;

    dec     = decode(~seg_s[6:0]);
    dec_ok  = dec[4];
    dec_nib = dec[3:0];
    pt_now  = ~seg_s[7];

    digit_evt = accept && (kind == SLOT_SINGLE);
    multi_evt = accept && (kind == SLOT_MULTI);
    publish   = digit_evt && (idx == 3'd7);
  end

  always_comb begin
    sh_nib_d = sh_nib_q;
    sh_pt_d  = sh_pt_q;
    sh_val_d = sh_val_q;
    seen_d   = seen_q;
    err_d    = err_q | multi_evt;
    data_d   = data_q;
    point_d  = point_q;
    valid_d  = valid_q;
    fv_d     = 1'b0;
    fe_d     = 1'b0;

    if (digit_evt) begin
      sh_nib_d[{idx, 2'b00} +: 4] = dec_nib;
      sh_pt_d[idx]                = pt_now;
      sh_val_d[idx]               = dec_ok;
      seen_d[idx]                 = 1'b1;
      err_d                       = err_q | !dec_ok;
    end

    // Digit 7 closes the frame: its fresh decode bypasses the shadow registers,
    // and digits not seen in this frame publish their stale nibble as invalid.
    if (publish) begin
      data_d  = {dec_nib, sh_nib_q[27:0]};
      point_d = {pt_now, sh_pt_q[6:0]};
      valid_d = {dec_ok, sh_val_q[6:0] & seen_q[6:0]};
      fv_d    = 1'b1;
      fe_d    = err_q | ~(&seen_q[6:0]) | !dec_ok;
      seen_d  = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      sample_q   <= '0;
      cnt_q      <= '0;
      accepted_q <= 1'b0;
      sh_nib_q   <= '0;
      sh_pt_q    <= '0;
      sh_val_q   <= '0;
      seen_q     <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
      point_q    <= '0;
      valid_q    <= '0;
      fv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      sample_q   <= sample_d;
      cnt_q      <= cnt_d;
      accepted_q <= accepted_d;
      sh_nib_q   <= sh_nib_d;
      sh_pt_q    <= sh_pt_d;
      sh_val_q   <= sh_val_d;
      seen_q     <= seen_d;
      err_q      <= err_d;
      data_q     <= data_d;
      point_q    <= point_d;
      valid_q    <= valid_d;
      fv_q       <= fv_d;
      fe_q       <= fe_d;
    end
  end

  assign data       = data_q;
  assign pointMask  = point_q;
  assign digitValid = valid_q;
  assign frameValid = fv_q;
  assign frameError = fe_q;

endmodule
